// File: rtl/lfsr_prbs_sync_check_pkg.sv
// Shared definitions for the PRBS sync checker: FSM encoding and width helpers.
package lfsr_prbs_sync_check_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } sync_state_e;

  function automatic int max_width(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lfsr_prbs_sync_check_lfsr.sv
// Combinational Fibonacci LFSR, non-reversed: advances the state DATA_WIDTH shifts
// and returns the extended output stream (newest bit in bit 0).
module lfsr_prbs_sync_check_lfsr #(
  parameter int                    LFSR_WIDTH   = 31,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY    = 31'h10000001,
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    OUTPUT_WIDTH = 31
) (
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic [LFSR_WIDTH-1:0]   state_in,
  output logic [OUTPUT_WIDTH-1:0] data_out,
  output logic [LFSR_WIDTH-1:0]   state_out
);

  logic [LFSR_WIDTH-1:0]   st_c;
  logic [OUTPUT_WIDTH-1:0] out_c;
  logic                    fb_c;

  // Bit 0 of the polynomial is the constant term and never taps the state.
  always_comb begin
    st_c  = state_in;
    out_c = OUTPUT_WIDTH'(state_in);
    fb_c  = 1'b0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      fb_c = st_c[LFSR_WIDTH-1] ^ data_in[i];
      for (int j = 1; j < LFSR_WIDTH; j++) begin
        if (LFSR_POLY[j]) fb_c = fb_c ^ st_c[j-1];
      end
      st_c  = {st_c[LFSR_WIDTH-2:0], fb_c};
      out_c = {out_c[OUTPUT_WIDTH-2:0], fb_c};
    end
  end

  assign data_out  = out_c;
  assign state_out = st_c;

endmodule

// File: rtl/lfsr_prbs_sync_check.sv
// PRBS checker: self-synchronises on the received stream, then free-runs its
// generator while locked and counts bit errors with saturation.
module lfsr_prbs_sync_check
  import lfsr_prbs_sync_check_pkg::*;
#(
  parameter int                    LFSR_WIDTH   = 31,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY    = 31'h10000001,
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    LOCK_COUNT   = 16,
  parameter int                    UNLOCK_COUNT = 4,
  parameter int                    COUNT_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  data_in,
  input  logic                   data_in_valid,
  input  logic                   count_clear,
  output logic [DATA_WIDTH-1:0]  err_out,
  output logic                   err_out_valid,
  output logic                   err_word,
  output logic                   locked,
  output logic [COUNT_WIDTH-1:0] err_count
);

  localparam int OUTPUT_WIDTH = max_width(LFSR_WIDTH, DATA_WIDTH);
  localparam int LCW          = $clog2(LOCK_COUNT + 1);
  localparam int UCW          = $clog2(UNLOCK_COUNT + 1);
  localparam int PCW          = $clog2(DATA_WIDTH + 1);
  localparam int SUMW         = max_width(COUNT_WIDTH, PCW) + 1;

  sync_state_e                    fsm_q, fsm_d;
  logic [LFSR_WIDTH-1:0]          state_q, state_d;
  logic [LCW-1:0]                 lock_cnt_q, lock_cnt_d;
  logic [UCW-1:0]                 unlock_cnt_q, unlock_cnt_d;
  logic [DATA_WIDTH-1:0]          err_out_q, err_out_d;
  logic                           err_out_valid_q, err_out_valid_d;
  logic                           err_word_q, err_word_d;
  logic                           locked_q, locked_d;
  logic [COUNT_WIDTH-1:0]         err_count_q, err_count_d;

  logic [OUTPUT_WIDTH-1:0]        gen_out;
  logic [LFSR_WIDTH-1:0]          gen_state;
  logic [DATA_WIDTH-1:0]          err_mask;
  logic [LFSR_WIDTH+DATA_WIDTH-1:0] hunt_cat;
  logic                           unused_hi;

  function automatic logic [PCW-1:0] popcount(input logic [DATA_WIDTH-1:0] v);
    logic [PCW-1:0] n;
    n = '0;
    for (int i = 0; i < DATA_WIDTH; i++) n = n + PCW'(v[i]);
    return n;
  endfunction

  function automatic logic [COUNT_WIDTH-1:0] sat_add(input logic [COUNT_WIDTH-1:0] base,
                                                     input logic [PCW-1:0]         inc);
    logic [SUMW-1:0] sum;
    sum = SUMW'(base) + SUMW'(inc);
    if (sum > SUMW'({COUNT_WIDTH{1'b1}})) return '1;
    else return sum[COUNT_WIDTH-1:0];
  endfunction

  lfsr_prbs_sync_check_lfsr #(
    .LFSR_WIDTH  (LFSR_WIDTH),
    .LFSR_POLY   (LFSR_POLY),
    .DATA_WIDTH  (DATA_WIDTH),
    .OUTPUT_WIDTH(OUTPUT_WIDTH)
  ) u_lfsr (
    .data_in  ('0),
    .state_in (state_q),
    .data_out (gen_out),
    .state_out(gen_state)
  );

  assign err_mask  = data_in ^ gen_out[DATA_WIDTH-1:0];
  assign hunt_cat  = {state_q, data_in};
  assign unused_hi = ^{gen_out, hunt_cat};

  // While hunting, the state is rebuilt from received bits; once locked it free-runs.
  always_comb begin
    fsm_d           = fsm_q;
    state_d         = state_q;
    lock_cnt_d      = lock_cnt_q;
    unlock_cnt_d    = unlock_cnt_q;
    err_out_d       = err_out_q;
    err_word_d      = err_word_q;
    err_out_valid_d = 1'b0;
    err_count_d     = count_clear ? '0 : err_count_q;
    if (data_in_valid) begin
      err_out_d       = err_mask;
      err_word_d      = |err_mask;
      err_out_valid_d = 1'b1;
      if (fsm_q == HUNT) begin
        state_d = hunt_cat[LFSR_WIDTH-1:0];
        if (|err_mask) begin
          lock_cnt_d = '0;
        end else if (lock_cnt_q + LCW'(1) == LCW'(LOCK_COUNT)) begin
          fsm_d        = LOCKED;
          lock_cnt_d   = '0;
          unlock_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + LCW'(1);
        end
      end else begin
        state_d     = gen_state;
        err_count_d = sat_add(err_count_d, popcount(err_mask));
        if (!(|err_mask)) begin
          unlock_cnt_d = '0;
        end else if (unlock_cnt_q + UCW'(1) == UCW'(UNLOCK_COUNT)) begin
          fsm_d        = HUNT;
          lock_cnt_d   = '0;
          unlock_cnt_d = '0;
        end else begin
          unlock_cnt_d = unlock_cnt_q + UCW'(1);
        end
      end
    end
    locked_d = (fsm_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q           <= HUNT;
      state_q         <= '0;
      lock_cnt_q      <= '0;
      unlock_cnt_q    <= '0;
      err_out_q       <= '0;
      err_out_valid_q <= 1'b0;
      err_word_q      <= 1'b0;
      locked_q        <= 1'b0;
      err_count_q     <= '0;
    end else begin
      fsm_q           <= fsm_d;
      state_q         <= state_d;
      lock_cnt_q      <= lock_cnt_d;
      unlock_cnt_q    <= unlock_cnt_d;
      err_out_q       <= err_out_d;
      err_out_valid_q <= err_out_valid_d;
      err_word_q      <= err_word_d;
      locked_q        <= locked_d;
      err_count_q     <= err_count_d;
    end
  end

  assign err_out       = err_out_q;
  assign err_out_valid = err_out_valid_q;
  assign err_word      = err_word_q;
  assign locked        = locked_q;
  assign err_count     = err_count_q;

endmodule

// File: tb/tb_lfsr_prbs_sync_check.sv
// Randomised bench for lfsr_prbs_sync_check against a bit-stream reference model
// (PRBS31 recurrence b[n] = b[n-31] ^ b[n-28]).
module tb_lfsr_prbs_sync_check;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  data_in = '0;
  logic        data_in_valid = 1'b0;
  logic        count_clear = 1'b0;
  logic [7:0]  err_out;
  logic        err_out_valid;
  logic        err_word;
  logic        locked;
  logic [31:0] err_count;
  logic [7:0]  unused_eo4;
  logic        unused_eov4;
  logic        unused_ew4;
  logic        locked4;
  logic [3:0]  err_count4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lfsr_prbs_sync_check dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
    .count_clear(count_clear), .err_out(err_out), .err_out_valid(err_out_valid),
    .err_word(err_word), .locked(locked), .err_count(err_count)
  );

  lfsr_prbs_sync_check #(.COUNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
    .count_clear(count_clear), .err_out(unused_eo4), .err_out_valid(unused_eov4),
    .err_word(unused_ew4), .locked(locked4), .err_count(err_count4)
  );

  // Reference model state
  bit         tx_q[$];
  bit         rx_q[$];
  bit         m_locked;
  int         m_lcnt, m_ucnt;
  logic [7:0] m_err_out;
  bit         m_valid, m_word;
  longint     m_ec32, m_ec4;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] tx_next();
    logic [7:0] w;
    bit b;
    for (int k = 7; k >= 0; k--) begin
      b = tx_q[tx_q.size() - 31] ^ tx_q[tx_q.size() - 28];
      tx_q.push_back(b);
      void'(tx_q.pop_front());
      w[k] = b;
    end
    return w;
  endfunction

  task automatic model_reset();
    rx_q = {};
    for (int i = 0; i < 31; i++) rx_q.push_back(1'b0);
    m_locked = 0; m_lcnt = 0; m_ucnt = 0;
    m_err_out = '0; m_valid = 0; m_word = 0;
    m_ec32 = 0; m_ec4 = 0;
  endtask

  task automatic model_step(input logic [7:0] d, input bit v, input bit cc, input bit r);
    bit         tmp[$];
    bit         b;
    logic [7:0] pred;
    bit         counted;
    longint     b32, b4, pc;
    if (r) begin
      model_reset();
    end else begin
      m_valid = v;
      counted = 0;
      if (v) begin
        tmp = rx_q;
        for (int k = 7; k >= 0; k--) begin
          b = tmp[tmp.size() - 31] ^ tmp[tmp.size() - 28];
          tmp.push_back(b);
          void'(tmp.pop_front());
          pred[k] = b;
        end
        m_err_out = d ^ pred;
        m_word    = |m_err_out;
        if (!m_locked) begin
          for (int k = 7; k >= 0; k--) begin
            rx_q.push_back(d[k]);
            void'(rx_q.pop_front());
          end
          if (m_word) m_lcnt = 0;
          else begin
            m_lcnt++;
            if (m_lcnt == 16) begin m_locked = 1; m_lcnt = 0; m_ucnt = 0; end
          end
        end else begin
          rx_q    = tmp;
          counted = 1;
          if (!m_word) m_ucnt = 0;
          else begin
            m_ucnt++;
            if (m_ucnt == 4) begin m_locked = 0; m_ucnt = 0; m_lcnt = 0; end
          end
        end
      end
      b32 = cc ? 0 : m_ec32;
      b4  = cc ? 0 : m_ec4;
      pc  = counted ? $countones(m_err_out) : 0;
      m_ec32 = (b32 + pc > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : b32 + pc;
      m_ec4  = (b4 + pc > 15) ? 15 : b4 + pc;
    end
  endtask

  task automatic step(input logic [7:0] d, input bit v, input bit cc, input bit r);
    data_in = d; data_in_valid = v; count_clear = cc; rst = r;
    @(posedge clk);
    model_step(d, v, cc, r);
    #1;
    check_eq("err_out_valid", err_out_valid, m_valid);
    check_eq("err_out", err_out, m_err_out);
    check_eq("err_word", err_word, m_word);
    check_eq("locked", locked, m_locked);
    check_eq("err_count", err_count, m_ec32);
    check_eq("locked4", locked4, m_locked);
    check_eq("err_count4", err_count4, m_ec4);
  endtask

  initial begin
    int         lock_idx, late_errs, pulses, accepted;
    bit         v, cc;
    logic [7:0] w, mask;

    for (int i = 0; i < 31; i++) tx_q.push_back(bit'($urandom_range(0, 1)));
    tx_q[0] = 1'b1;
    model_reset();

    for (int i = 0; i < 3; i++) step(8'h00, 0, 0, 1);
    check_eq("rst_locked", locked, 0);
    check_eq("rst_err_count", err_count, 0);
    check_eq("rst_err_out", err_out, 0);
    check_eq("rst_err_out_valid", err_out_valid, 0);

    // Clean stream, valid every cycle
    lock_idx = -1; late_errs = 0;
    for (int i = 1; i <= 1000; i++) begin
      step(tx_next(), 1, 0, 0);
      if (locked && lock_idx < 0) lock_idx = i;
      if (i > 4 && err_word) late_errs++;
    end
    check_eq("clean_lock_window", (lock_idx >= 16 && lock_idx <= 20), 1);
    check_eq("clean_late_errs", late_errs, 0);
    check_eq("clean_err_count", err_count, 0);

    // Single bit-3 flip while locked
    step(tx_next() ^ 8'h08, 1, 0, 0);
    check_eq("flip_mask", err_out, 8'h08);
    check_eq("flip_locked", locked, 1);
    check_eq("flip_count", err_count, 1);
    late_errs = 0;
    for (int i = 0; i < 20; i++) begin
      step(tx_next(), 1, 0, 0);
      if (err_word) late_errs++;
    end
    check_eq("flip_followon", late_errs, 0);

    // Four inverted words drop lock
    step(8'h00, 0, 1, 0);
    check_eq("clear_alone", err_count, 0);
    for (int i = 1; i <= 4; i++) begin
      step(~tx_next(), 1, 0, 0);
      if (i == 3) check_eq("inv3_still_locked", locked, 1);
    end
    check_eq("inv4_locked", locked, 0);
    check_eq("inv4_count", err_count, 32);
    check_eq("inv4_count4_sat", err_count4, 4'hF);
    lock_idx = -1;
    for (int i = 1; i <= 30; i++) begin
      step(tx_next(), 1, 0, 0);
      if (locked && lock_idx < 0) lock_idx = i;
    end
    check_eq("relock_words", lock_idx, 16);
    check_eq("sat_hold4", err_count4, 4'hF);

    // count_clear together with an 8-error word
    step(~tx_next(), 1, 1, 0);
    check_eq("clear_with_word", err_count, 8);
    check_eq("clear_with_word4", err_count4, 8);
    step(tx_next(), 1, 0, 0);

    // Random valid gaps with sparse single-bit errors
    pulses = 0; accepted = 0;
    for (int i = 0; i < 400; i++) begin
      v    = bit'($urandom_range(0, 1));
      mask = ($urandom_range(0, 39) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      cc   = ($urandom_range(0, 49) == 0);
      if (v) begin w = tx_next() ^ mask; accepted++; end
      else w = 8'($urandom);
      step(w, v, cc, 0);
      if (err_out_valid) pulses++;
    end
    check_eq("gap_pulse_count", pulses, accepted);

    // Reset while locked, with a word presented in the same cycle
    for (int i = 0; i < 40; i++) step(tx_next(), 1, 0, 0);
    check_eq("pre_rst_locked", locked, 1);
    step(tx_next(), 1, 0, 1);
    check_eq("rst_mid_locked", locked, 0);
    check_eq("rst_mid_count", err_count, 0);
    check_eq("rst_mid_valid", err_out_valid, 0);
    lock_idx = -1;
    for (int i = 1; i <= 30; i++) begin
      step(tx_next(), 1, 0, 0);
      if (locked && lock_idx < 0) lock_idx = i;
    end
    check_eq("rst_relock_window", (lock_idx >= 16 && lock_idx <= 20), 1);

    // Mixed random traffic: gaps, error bursts, clears, occasional reset
    for (int i = 0; i < 800; i++) begin
      v    = ($urandom_range(0, 3) != 0);
      mask = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'h00;
      if ($urandom_range(0, 59) == 0) mask = 8'hFF;
      cc   = ($urandom_range(0, 29) == 0);
      w    = v ? (tx_next() ^ mask) : 8'($urandom);
      step(w, v, cc, ($urandom_range(0, 249) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
